// File: rtl/snell_seq.sv
// snell_seq: sequences n2/theta1/theta2 operands into a snell_law core and returns its result.
// Latency: CALC_LAT+2 cycles from the last L_T2 select cycle to res_valid rising (6 at defaults).
// Backpressure: in_ready only in W_N2/W_T1/W_T2; res_valid/res_data are held until res_ready.
//
// Ports:
//   clk, rst               - clock; asynchronous active-low reset
//   in_valid/in_ready/in_data - operand words, in order n2, theta1, theta2
//   n2_sel/t1_sel/t2_sel   - load selects to snell_law, each held SEL_HOLD cycles
//   out_sel                - output select, held through CALC and CAP
//   input_port/output_port - operand to snell_law / result from snell_law
//   res_valid/res_ready/res_data - captured result handshake
//   busy                   - low only when idle in W_N2
//   err                    - one-cycle pulse on a rejected operand
// Optional feature: define SNELL_RANGE_CHK_EN to reject n2==0 and theta>90.
module snell_seq #(
    parameter int CALC_LAT = 4,   // 1..15
    parameter int SEL_HOLD = 2    // 1..7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] in_data,
    output logic       in_ready,
    output logic       n2_sel,
    output logic       t1_sel,
    output logic       t2_sel,
    output logic       out_sel,
    output logic [6:0] input_port,
    input  logic [6:0] output_port,
    output logic       res_valid,
    output logic [6:0] res_data,
    input  logic       res_ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [3:0] {
        W_N2, L_N2, W_T1, L_T1, W_T2, L_T2, CALC, CAP, OUT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] inport_q, inport_d;
    logic [6:0] res_q, res_d;
    logic       accept;
    logic       hold_done;
    logic       calc_done;

`ifdef SNELL_RANGE_CHK_EN
    logic       err_q, err_d;
    logic       range_bad;
    // n2 of zero is meaningless; angles beyond 90 degrees are out of the core's domain
    assign range_bad = (state_q == W_N2) ? (in_data == 7'd0) : (in_data > 7'd90);
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    // Selects decode straight from the state register so reset drops them asynchronously
    assign in_ready   = (state_q == W_N2) || (state_q == W_T1) || (state_q == W_T2);
    assign n2_sel     = (state_q == L_N2);
    assign t1_sel     = (state_q == L_T1);
    assign t2_sel     = (state_q == L_T2);
    assign out_sel    = (state_q == CALC) || (state_q == CAP);
    assign res_valid  = (state_q == OUT);
    assign busy       = (state_q != W_N2);
    assign input_port = inport_q;
    assign res_data   = res_q;

    assign accept    = in_valid && in_ready;
    assign hold_done = (cnt_q == 4'(SEL_HOLD - 1));
    assign calc_done = (cnt_q == 4'(CALC_LAT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inport_d = inport_q;
        res_d    = res_q;
`ifdef SNELL_RANGE_CHK_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            W_N2, W_T1, W_T2: begin
                if (accept) begin
                    cnt_d    = 4'd0;
                    inport_d = in_data;
                    case (state_q)
                        W_N2:    state_d = L_N2;
                        W_T1:    state_d = L_T1;
                        default: state_d = L_T2;
                    endcase
`ifdef SNELL_RANGE_CHK_EN
                    // Rejected word abandons the whole triple without raising any select
                    if (range_bad) begin
                        state_d  = W_N2;
                        inport_d = 7'd0;
                        err_d    = 1'b1;
                    end
`endif
                end
            end
            L_N2, L_T1, L_T2: begin
                if (hold_done) begin
                    cnt_d = 4'd0;
                    case (state_q)
                        L_N2:    state_d = W_T1;
                        L_T1:    state_d = W_T2;
                        default: begin
                            state_d  = CALC;
                            inport_d = 7'd0;   // operand bus idles at zero while computing
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CALC: begin
                if (calc_done) begin
                    cnt_d   = 4'd0;
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAP: begin
                res_d   = output_port;
                state_d = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    state_d = W_N2;
                end
            end
            default: state_d = W_N2;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= W_N2;
            cnt_q    <= 4'd0;
            inport_q <= 7'd0;
            res_q    <= 7'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inport_q <= inport_d;
            res_q    <= res_d;
        end
    end

`ifdef SNELL_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_snell_seq.sv
module tb_snell_seq;
    localparam int CALC_LAT = 4;
    localparam int SEL_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic       n2_sel, t1_sel, t2_sel, out_sel;
    logic [6:0] input_port;
    logic [6:0] output_port;
    logic       res_valid;
    logic [6:0] res_data;
    logic       res_ready;
    logic       busy;
    logic       err;

    snell_seq #(.CALC_LAT(CALC_LAT), .SEL_HOLD(SEL_HOLD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .n2_sel(n2_sel), .t1_sel(t1_sel), .t2_sel(t2_sel), .out_sel(out_sel),
        .input_port(input_port), .output_port(output_port),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] k;
        logic [6:0] v;
    } selx_t;

    selx_t      sel_q[$];
    logic [6:0] res_q[$];
    int         out_run  = 0;
    int         lat_cnt  = 0;
    bit         lat_arm  = 1'b0;
    int         err_cnt  = 0;
    int         xfer_cnt = 0;
    int         rv_run   = 0;
    int         last_rv_run = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, stimulus changes just after the rising edge
    always @(negedge clk) begin
        if (!rst) begin
            out_run = 0;
            lat_arm = 1'b0;
            rv_run  = 0;
        end else begin
            chk("sel_onehot", int'($countones({n2_sel, t1_sel, t2_sel, out_sel}) <= 1), 1);
            if (n2_sel || t1_sel || t2_sel) begin
                if (sel_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sel_unexpected: got n2/t1/t2=%b%b%b with no select expected",
                             n2_sel, t1_sel, t2_sel);
                end else begin
                    selx_t e;
                    e = sel_q.pop_front();
                    chk("sel_kind", n2_sel ? 0 : (t1_sel ? 1 : 2), int'(e.k));
                    chk("sel_input_port", int'(input_port), int'(e.v));
                end
            end
            if (out_sel) begin
                out_run++;
            end else if (out_run != 0) begin
                chk("out_sel_len", out_run, CALC_LAT + 1);
                out_run = 0;
            end
            if (t2_sel) begin
                lat_cnt = 0;
                lat_arm = 1'b1;
            end else if (lat_arm) begin
                lat_cnt++;
                if (res_valid) begin
                    chk("latency", lat_cnt, CALC_LAT + 2);
                    lat_arm = 1'b0;
                end
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL res_unexpected: got res_data=%0d with no result expected", res_data);
                end else begin
                    chk("res_data", int'(res_data), int'(res_q.pop_front()));
                end
                xfer_cnt++;
            end
            if (res_valid) begin
                rv_run++;
            end else if (rv_run != 0) begin
                last_rv_run = rv_run;
                rv_run = 0;
            end
            if (err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; expected select activity is queued when the transfer is due
    task automatic send(input logic [6:0] w, input logic [1:0] k, input bit exp_sel);
        bit acc;
        selx_t e;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                if (exp_sel) begin
                    e.k = k;
                    e.v = w;
                    for (int j = 0; j < SEL_HOLD; j++) sel_q.push_back(e);
                end
                tick();
                acc = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    // Idle cycles; while the DUT is not ready, in_valid is waved with junk to show it is ignored
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = !in_ready && ($urandom_range(0, 1) == 1);
            in_data  = 7'h7F;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_triple(input logic [6:0] n2, input logic [6:0] t1, input logic [6:0] t2,
                               input logic [6:0] res, input bit gaps);
        output_port = res;
        send(n2, 2'd0, 1'b1);
        if (gaps) gap($urandom_range(0, 4));
        send(t1, 2'd1, 1'b1);
        if (gaps) gap($urandom_range(0, 4));
        send(t2, 2'd2, 1'b1);
        res_q.push_back(res);
    endtask

    task automatic wait_result();
        int start;
        start = xfer_cnt;
        for (int i = 0; i < 200; i++) begin
            if (xfer_cnt > start) break;
            tick();
        end
        chk("result_transfers", xfer_cnt - start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int xs;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 7'd0;
        res_ready = 1'b0;
        output_port = 7'd0;
        repeat (3) tick();

        // Reset state
        chk("reset_selects", int'({n2_sel, t1_sel, t2_sel, out_sel}), 0);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_input_port", int'(input_port), 0);
        chk("reset_res_data", int'(res_data), 0);
        rst = 1'b1;
        @(posedge clk);
        chk("in_ready_after_reset", int'(in_ready), 1);
        #1;

        // Basic triple, res_ready held high
        res_ready = 1'b1;
        send_triple(7'd10, 7'd1, 7'd1, 7'h2A, 1'b0);
        wait_result();
        tick();
        chk("res_valid_len", last_rv_run, 1);
        chk("idle_busy", int'(busy), 0);

        // Backpressure on the result side
        res_ready = 1'b0;
        send_triple(7'd20, 7'd30, 7'd45, 7'h11, 1'b0);
        for (int i = 0; i < 200 && !res_valid; i++) tick();
        xs = xfer_cnt;
        for (int i = 0; i < 20; i++) begin
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_data", int'(res_data), 7'h11);
            chk("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp_one_transfer", xfer_cnt - xs, 1);
        chk("bp_res_valid_drop", int'(res_valid), 0);

        // Reset while t1_sel is being held
        send(7'd5, 2'd0, 1'b1);
        gap(SEL_HOLD);
        send(7'd9, 2'd1, 1'b1);
        chk("pre_reset_t1_sel", int'(t1_sel), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_t1_sel_drop", int'(t1_sel), 0);
        chk("async_busy_drop", int'(busy), 0);
        sel_q.delete();
        tick();
        rst = 1'b1;
        chk("post_reset_in_ready", int'(in_ready), 1);
        chk("post_reset_input_port", int'(input_port), 0);
        send_triple(7'd3, 7'd40, 7'd50, 7'h33, 1'b0);
        wait_result();

        // Gaps between words and res_ready toggling while idle
        xs = xfer_cnt;
        for (int t = 0; t < 3; t++) begin
            res_ready = 1'b1;
            send_triple(7'(12 + t), 7'(20 + 5 * t), 7'(60 + t), 7'(7'h40 + t), 1'b1);
            wait_result();
            for (int i = 0; i < 4; i++) begin
                res_ready = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        chk("gap_transfers", xfer_cnt - xs, 3);

        // Out-of-range theta1
        res_ready = 1'b1;
        err_cnt = 0;
        output_port = 7'h5A;
        send(7'd10, 2'd0, 1'b1);
`ifdef SNELL_RANGE_CHK_EN
        send(7'd95, 2'd1, 1'b0);
        repeat (4) tick();
        chk("range_err_pulses", err_cnt, 1);
        chk("range_back_to_idle", int'(busy), 0);
        chk("range_in_ready", int'(in_ready), 1);
`else
        send(7'd95, 2'd1, 1'b1);
        send(7'd7, 2'd2, 1'b1);
        res_q.push_back(7'h5A);
        wait_result();
        chk("range_err_tied", err_cnt, 0);
`endif
        repeat (SEL_HOLD + 2) tick();
        chk("sel_queue_drained", sel_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
